// File: rtl/prog_rom_bus_ctl_pkg.sv
// Shared definitions for the program ROM bus controller: ROM geometry,
// wait-state counter width and the controller state encoding.
package prog_rom_bus_ctl_pkg;

  localparam int ROM_AW = 13;  // word address width of one 8Kx8 ROM
  localparam int ROM_DW = 8;   // data width of one ROM (one byte lane)
  localparam int WS_W   = 3;   // wait-state counter width (0..7)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WAIT,
    ST_ACK
  } state_e;

endpackage

// File: rtl/prog_rom_bus_ctl_if.sv
// 68000-side bus as seen by the ROM controller: the CPU (master) drives the
// address/strobe/direction, the controller (slave) returns data and DTACK.
interface prog_rom_bus_ctl_if;

  logic [23:1] cpu_a;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic [15:0] cpu_d_out;
  logic        cpu_d_oe;
  logic        cpu_dtack_n;

  modport master (
    output cpu_a, cpu_as_n, cpu_rw,
    input  cpu_d_out, cpu_d_oe, cpu_dtack_n
  );

  modport slave (
    input  cpu_a, cpu_as_n, cpu_rw,
    output cpu_d_out, cpu_d_oe, cpu_dtack_n
  );

endinterface

// File: rtl/prog_rom_bus_ctl_pair_mux.sv
// Selects the {hi, lo} byte pair of one ROM pair out of the packed ROM
// output buses and merges it into a 16-bit CPU word.
module prog_rom_bus_ctl_pair_mux
  import prog_rom_bus_ctl_pkg::*;
#(
  parameter int PAIR_BITS = 2
) (
  input  logic [PAIR_BITS-1:0]               pair_i,
  input  logic [ROM_DW*(2**PAIR_BITS)-1:0]   rom_d_hi_i,
  input  logic [ROM_DW*(2**PAIR_BITS)-1:0]   rom_d_lo_i,
  output logic [2*ROM_DW-1:0]                word_o
);

  // Pair p occupies bits [8p+7:8p] of each packed bus.
  assign word_o = {rom_d_hi_i[int'(pair_i)*ROM_DW +: ROM_DW],
                   rom_d_lo_i[int'(pair_i)*ROM_DW +: ROM_DW]};

endmodule

// File: rtl/prog_rom_bus_ctl.sv
// 68000-side controller for the program ROM array. Decodes the CPU address,
// drives the shared ROM address and one-hot chip enables, absorbs the ROMs'
// one-cycle registered read latency, adds optional wait states and keeps a
// one-word cache of the last ROM read. All outputs are registered.
module prog_rom_bus_ctl
  import prog_rom_bus_ctl_pkg::*;
#(
  parameter int          PAIR_BITS   = 2,
  parameter logic [23:0] BASE        = 24'h000000,
  parameter int          WAIT_STATES = 0,
  parameter bit          CACHE_EN    = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  prog_rom_bus_ctl_if.slave                 bus,
  output logic [ROM_AW-1:0]                 rom_a,
  output logic [(2**PAIR_BITS)-1:0]         rom_ce,
  input  logic [ROM_DW*(2**PAIR_BITS)-1:0]  rom_d_hi,
  input  logic [ROM_DW*(2**PAIR_BITS)-1:0]  rom_d_lo,
  output logic                              wr_err
);

  localparam int NUM_PAIRS = 2**PAIR_BITS;
  localparam int TAG_LSB   = 14 + PAIR_BITS;

  state_e                 state_q;
  logic [WS_W-1:0]        ws_cnt_q;
  logic [PAIR_BITS-1:0]   pair_q;
  logic [23:1]            cur_a_q;
  logic [ROM_AW-1:0]      rom_a_q;
  logic [NUM_PAIRS-1:0]   rom_ce_q;
  logic [15:0]            d_out_q;
  logic                   d_oe_q;
  logic                   dtack_n_q;
  logic                   wr_err_q;
  logic                   cache_vld_q;
  logic [23:1]            cache_a_q;
  logic [15:0]            cache_d_q;

  logic                   hit;
  logic                   cache_hit;
  logic [PAIR_BITS-1:0]   pair;
  logic [ROM_AW-1:0]      word;
  logic [15:0]            rom_word;

  // Address decode: window tag, pair select and ROM word index.
  assign hit       = !bus.cpu_as_n && (bus.cpu_a[23:TAG_LSB] == BASE[23:TAG_LSB]);
  assign pair      = bus.cpu_a[13+PAIR_BITS:14];
  assign word      = bus.cpu_a[13:1];
  assign cache_hit = CACHE_EN && cache_vld_q && (bus.cpu_a == cache_a_q);

  // The pair index is registered at request time so the mux stays stable
  // while the ROM output is captured.
  prog_rom_bus_ctl_pair_mux #(
    .PAIR_BITS (PAIR_BITS)
  ) u_pair_mux (
    .pair_i     (pair_q),
    .rom_d_hi_i (rom_d_hi),
    .rom_d_lo_i (rom_d_lo),
    .word_o     (rom_word)
  );

  // Bus FSM with registered outputs, wait counter and last-word cache.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ws_cnt_q    <= '0;
      pair_q      <= '0;
      cur_a_q     <= '0;
      rom_a_q     <= '0;
      rom_ce_q    <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      dtack_n_q   <= 1'b1;
      wr_err_q    <= 1'b0;
      cache_vld_q <= 1'b0;
      cache_a_q   <= '0;
      cache_d_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values held before the edge, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (!bus.cpu_rw) begin
              // Writes to ROM are acknowledged without touching the ROMs.
              wr_err_q  <= 1'b1;
              dtack_n_q <= 1'b0;
              d_oe_q    <= 1'b0;
              state_q   <= ST_ACK;
            end else if (cache_hit) begin
              d_out_q   <= cache_d_q;
              dtack_n_q <= 1'b0;
              d_oe_q    <= 1'b1;
              state_q   <= ST_ACK;
            end else begin
              rom_a_q  <= word;
              rom_ce_q <= NUM_PAIRS'(1) << pair;
              pair_q   <= pair;
              cur_a_q  <= bus.cpu_a;
              state_q  <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          // ROMs sample rom_a on this edge; data is valid after it.
          if (bus.cpu_as_n) begin
            rom_ce_q <= '0;
            state_q  <= ST_IDLE;
          end else begin
            state_q  <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          rom_ce_q    <= '0;
          d_out_q     <= rom_word;
          cache_vld_q <= 1'b1;
          cache_a_q   <= cur_a_q;
          cache_d_q   <= rom_word;
          if (bus.cpu_as_n) begin
            state_q <= ST_IDLE;
          end else if (WAIT_STATES == 0) begin
            dtack_n_q <= 1'b0;
            d_oe_q    <= 1'b1;
            state_q   <= ST_ACK;
          end else begin
            ws_cnt_q <= WS_W'(WAIT_STATES);
            state_q  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.cpu_as_n) begin
            state_q <= ST_IDLE;
          end else if (ws_cnt_q == WS_W'(1)) begin
            dtack_n_q <= 1'b0;
            d_oe_q    <= 1'b1;
            state_q   <= ST_ACK;
          end else begin
            ws_cnt_q <= ws_cnt_q - WS_W'(1);
          end
        end

        ST_ACK: begin
          // Hold the acknowledge until the CPU drops its strobe.
          if (bus.cpu_as_n) begin
            dtack_n_q <= 1'b1;
            d_oe_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_d_out   = d_out_q;
  assign bus.cpu_d_oe    = d_oe_q;
  assign bus.cpu_dtack_n = dtack_n_q;
  assign rom_a           = rom_a_q;
  assign rom_ce          = rom_ce_q;
  assign wr_err          = wr_err_q;

endmodule
